// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO-status generator and the monitoring FSM side:
//   - default geometry and threshold constants
//   - state encoding of the generator's control FSM
//   - flag decode function (count vs. thresholds), also used by the FSM bench
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_PTR_W  = 3;
    localparam int FIFO_AF_DEF = 6;
    localparam int FIFO_AE_DEF = 2;

    typedef enum logic [1:0] {
        ST_CFG = 2'd0,
        ST_RUN = 2'd1,
        ST_ERR = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic almost_full;
        logic almost_empty;
        logic empty;
        logic no_empty;
    } fifo_flags_t;

    // Literal compares: an inverted threshold pair (af <= ae) is not corrected.
    // Arguments are zero-extended to 8 bits so any PTR_W up to 7 fits.
    function automatic fifo_flags_t fifo_decode_flags(input logic [7:0] cnt,
                                                      input logic [7:0] thr_af,
                                                      input logic [7:0] thr_ae);
        fifo_flags_t f;
        f.almost_full  = (cnt >= thr_af);
        f.almost_empty = (cnt <= thr_ae);
        f.empty        = (cnt == 8'd0);
        f.no_empty     = (cnt != 8'd0);
        return f;
    endfunction

endpackage

// File: rtl/fifo_status_gen_if.sv
// fifo_status_gen_if
// Bus between the upstream source / monitoring FSM and fifo_status_gen.
//   master : the generator side (takes requests, drives data and status)
//   slave  : the source/FSM side (drives requests, observes data and status)
// Signals: init, thr_af, thr_ae, push, data_in, pop, pausa, continua,
//          data_Fifo, valid_out, almost_full, almost_empty, empty_Fifo,
//          no_empty_Fifo, Fifo_overflow, stalled, count
// Build option: FIFO_UNDERFLOW_EN adds Fifo_underflow.
interface fifo_status_gen_if #(
    parameter int DATA_W = fifo_pkg::FIFO_DATA_W,
    parameter int PTR_W  = fifo_pkg::FIFO_PTR_W
);
    logic              init;
    logic [PTR_W:0]    thr_af;
    logic [PTR_W:0]    thr_ae;
    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [DATA_W-1:0] pausa;
    logic [DATA_W-1:0] continua;
    logic [DATA_W-1:0] data_Fifo;
    logic              valid_out;
    logic              almost_full;
    logic              almost_empty;
    logic              empty_Fifo;
    logic              no_empty_Fifo;
    logic              Fifo_overflow;
    logic              stalled;
    logic [PTR_W:0]    count;
`ifdef FIFO_UNDERFLOW_EN
    logic              Fifo_underflow;

    modport master (
        input  init, thr_af, thr_ae, push, data_in, pop, pausa, continua,
        output data_Fifo, valid_out, almost_full, almost_empty, empty_Fifo,
               no_empty_Fifo, Fifo_overflow, stalled, count, Fifo_underflow
    );

    modport slave (
        output init, thr_af, thr_ae, push, data_in, pop, pausa, continua,
        input  data_Fifo, valid_out, almost_full, almost_empty, empty_Fifo,
               no_empty_Fifo, Fifo_overflow, stalled, count, Fifo_underflow
    );
`else
    modport master (
        input  init, thr_af, thr_ae, push, data_in, pop, pausa, continua,
        output data_Fifo, valid_out, almost_full, almost_empty, empty_Fifo,
               no_empty_Fifo, Fifo_overflow, stalled, count
    );

    modport slave (
        output init, thr_af, thr_ae, push, data_in, pop, pausa, continua,
        input  data_Fifo, valid_out, almost_full, almost_empty, empty_Fifo,
               no_empty_Fifo, Fifo_overflow, stalled, count
    );
`endif

endinterface

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p
// DEPTH x DATA_W register array with one write port and one registered read
// port. A read and a write to the same address in the same cycle returns the
// old contents (needed when the FIFO is full and pushes/pops together).
// Ports:
//   clk, reset          : clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data
//   rd_en/rd_addr       : read register loads only when rd_en=1, else holds
//   rd_data             : registered read data
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_status_gen.sv
// fifo_status_gen
// Synchronous FIFO producing the data word and status flags consumed by the
// FIFO-monitoring FSM, with pausa/continua write-side flow control.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : fifo_status_gen_if.master (requests in, data and status out)
// Build option: FIFO_UNDERFLOW_EN adds a sticky Fifo_underflow flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// CFG   | FIFO cleared, thresholds loaded while init=1, push/pop ignored
// RUN   | normal operation
// ERR   | overflow seen; Fifo_overflow held, pops allowed, pushes dropped
module fifo_status_gen
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int PTR_W  = FIFO_PTR_W,
    parameter int AF_DEF = FIFO_AF_DEF,
    parameter int AE_DEF = FIFO_AE_DEF
) (
    input logic                clk,
    input logic                reset,
    fifo_status_gen_if.master  bus
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    fifo_state_e      state_q,   state_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PTR_W:0]   count_q,   count_d;
    logic [PTR_W:0]   thr_af_q,  thr_af_d;
    logic [PTR_W:0]   thr_ae_q,  thr_ae_d;
    logic             ovf_q,     ovf_d;
    logic             stalled_q, stalled_d;
    logic             valid_q,   valid_d;
`ifdef FIFO_UNDERFLOW_EN
    logic             unf_q,     unf_d;
`endif

    logic             cfg_act;
    logic             wr_accept;
    logic             rd_accept;
    logic             ovf_event;
    fifo_flags_t      flags;

    // init acts as CFG in the very cycle it is raised, so the FIFO is
    // cleared and push/pop are ignored without a one-cycle lag.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        thr_af_d  = thr_af_q;
        thr_ae_d  = thr_ae_q;
        ovf_d     = ovf_q;
        stalled_d = stalled_q;
`ifdef FIFO_UNDERFLOW_EN
        unf_d     = unf_q;
`endif
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        ovf_event = 1'b0;
        cfg_act   = bus.init || (state_q == ST_CFG);

        if (cfg_act) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            stalled_d = 1'b0;
`ifdef FIFO_UNDERFLOW_EN
            unf_d     = 1'b0;
`endif
            if (bus.init) begin
                thr_af_d = bus.thr_af;
                thr_ae_d = bus.thr_ae;
            end
        end else begin
            rd_accept = bus.pop && (count_q != '0);

            // ERR drops every push; stall drops silently without overflow.
            if (bus.push && !stalled_q && (state_q == ST_RUN)) begin
                if ((count_q != FULL_CNT) || bus.pop) begin
                    wr_accept = 1'b1;
                end else begin
                    ovf_event = 1'b1;
                end
            end

            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            if (ovf_event) begin
                ovf_d = 1'b1;
            end

            // pausa has priority over continua
            if (|bus.pausa) begin
                stalled_d = 1'b1;
            end else if (|bus.continua) begin
                stalled_d = 1'b0;
            end

`ifdef FIFO_UNDERFLOW_EN
            if (bus.pop && (count_q == '0)) begin
                unf_d = 1'b1;
            end
`endif
        end

        if (bus.init) begin
            state_d = ST_CFG;
        end else begin
            case (state_q)
                ST_CFG:  state_d = ST_RUN;
                ST_RUN:  state_d = ovf_event ? ST_ERR : ST_RUN;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_CFG;
            endcase
        end

        valid_d = rd_accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CFG;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            thr_af_q  <= (PTR_W+1)'(AF_DEF);
            thr_ae_q  <= (PTR_W+1)'(AE_DEF);
            ovf_q     <= 1'b0;
            stalled_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            thr_af_q  <= thr_af_d;
            thr_ae_q  <= thr_ae_d;
            ovf_q     <= ovf_d;
            stalled_q <= stalled_d;
            valid_q   <= valid_d;
        end
    end

`ifdef FIFO_UNDERFLOW_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unf_q <= 1'b0;
        end else begin
            unf_q <= unf_d;
        end
    end

    assign bus.Fifo_underflow = unf_q;
`endif

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.data_Fifo)
    );

    // Flags decode the registered count directly: no extra pipeline stage.
    assign flags = fifo_decode_flags(8'(count_q), 8'(thr_af_q), 8'(thr_ae_q));

    assign bus.valid_out     = valid_q;
    assign bus.almost_full   = flags.almost_full;
    assign bus.almost_empty  = flags.almost_empty;
    assign bus.empty_Fifo    = flags.empty;
    assign bus.no_empty_Fifo = flags.no_empty;
    assign bus.Fifo_overflow = ovf_q;
    assign bus.stalled       = stalled_q;
    assign bus.count         = count_q;

endmodule

// File: tb/tb_fifo_status_gen.sv
// tb_fifo_status_gen
// Directed bench for fifo_status_gen. A behavioural FIFO model predicts
// occupancy, flags, stall and overflow each cycle; every accepted pop pushes
// its expected word to a scoreboard that is drained when valid_out is seen.
module tb_fifo_status_gen;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_status_gen_if bus ();

    fifo_status_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_q   [$];
    logic [7:0] exp_q [$];
    logic [7:0] e_w;
    bit         m_cfg;
    bit         m_err;
    bit         m_stalled;
    bit         m_valid;
    int         m_af;
    int         m_ae;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("valid_out_unexpected", 32'(bus.valid_out), 32'd0);
            end else begin
                e_w = exp_q.pop_front();
                chk("data_Fifo", 32'(bus.data_Fifo), 32'(e_w));
            end
        end
    end

    task automatic check_model();
        int n;
        n = m_q.size();
        chk("count",         32'(bus.count),         32'(n));
        chk("empty_Fifo",    32'(bus.empty_Fifo),    32'(n == 0));
        chk("no_empty_Fifo", 32'(bus.no_empty_Fifo), 32'(n != 0));
        chk("almost_full",   32'(bus.almost_full),   32'(n >= m_af));
        chk("almost_empty",  32'(bus.almost_empty),  32'(n <= m_ae));
        chk("Fifo_overflow", 32'(bus.Fifo_overflow), 32'(m_err));
        chk("stalled",       32'(bus.stalled),       32'(m_stalled));
        chk("valid_out",     32'(bus.valid_out),     32'(m_valid));
    endtask

    // One clock cycle: drive inputs, advance the model, then check after the edge.
    task automatic cyc(input logic p, input logic [7:0] d, input logic q,
                       input logic [7:0] pa = 8'h00, input logic [7:0] co = 8'h00,
                       input logic ini = 1'b0);
        bit rd;
        bit wr;
        bus.push     = p;
        bus.data_in  = d;
        bus.pop      = q;
        bus.pausa    = pa;
        bus.continua = co;
        bus.init     = ini;
        rd = 1'b0;
        wr = 1'b0;
        if (ini || m_cfg) begin
            m_q.delete();
            m_err     = 1'b0;
            m_stalled = 1'b0;
            if (ini) begin
                m_af = int'(bus.thr_af);
                m_ae = int'(bus.thr_ae);
            end
            m_cfg = ini;
        end else begin
            rd = q && (m_q.size() > 0);
            if (p && !m_stalled && !m_err) begin
                if (m_q.size() < 8 || q) wr = 1'b1;
                else m_err = 1'b1;
            end
            if (rd) exp_q.push_back(m_q.pop_front());
            if (wr) m_q.push_back(d);
            if (pa != 8'h00) m_stalled = 1'b1;
            else if (co != 8'h00) m_stalled = 1'b0;
        end
        m_valid = rd;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cfg     = 1'b1;
        m_err     = 1'b0;
        m_stalled = 1'b0;
        m_valid   = 1'b0;
        m_af      = 6;
        m_ae      = 2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        bus.init     = 1'b0;
        bus.thr_af   = 4'd6;
        bus.thr_ae   = 4'd2;
        bus.push     = 1'b0;
        bus.data_in  = 8'h00;
        bus.pop      = 1'b0;
        bus.pausa    = 8'h00;
        bus.continua = 8'h00;
        model_reset();

        @(posedge clk);
        #1;
        chk("rst_count",         32'(bus.count),         32'd0);
        chk("rst_empty",         32'(bus.empty_Fifo),    32'd1);
        chk("rst_almost_empty",  32'(bus.almost_empty),  32'd1);
        chk("rst_no_empty",      32'(bus.no_empty_Fifo), 32'd0);
        chk("rst_almost_full",   32'(bus.almost_full),   32'd0);
        chk("rst_overflow",      32'(bus.Fifo_overflow), 32'd0);
        chk("rst_stalled",       32'(bus.stalled),       32'd0);
        chk("rst_valid",         32'(bus.valid_out),     32'd0);
        chk("rst_data",          32'(bus.data_Fifo),     32'd0);
        reset = 1'b0;

        // init with default thresholds, then one CFG cycle to reach RUN
        cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
        cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
        cyc(0, 8'h00, 0);
        chk("init_data", 32'(bus.data_Fifo), 32'd0);

        // six pushes, six pops in order
        for (int i = 0; i < 6; i++) cyc(1, 8'h11 + 8'(i), 0);
        chk("af_after_6", 32'(bus.almost_full), 32'd1);
        chk("count_6",    32'(bus.count),       32'd6);
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);                     // pop on empty: ignored
`ifdef FIFO_UNDERFLOW_EN
        chk("underflow", 32'(bus.Fifo_underflow), 32'd1);
`endif

        // overflow: nine pushes, extra pushes dropped in ERR, drain, clear
        for (int i = 0; i < 9; i++) cyc(1, 8'h20 + 8'(i), 0);
        chk("ovf_set",   32'(bus.Fifo_overflow), 32'd1);
        chk("ovf_count", 32'(bus.count),         32'd8);
        cyc(1, 8'h5A, 0);
        cyc(1, 8'h5B, 1);
        for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
        chk("ovf_cleared", 32'(bus.Fifo_overflow), 32'd0);
        cyc(0, 8'h00, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) cyc(1, 8'h30 + 8'(i), 0);
        cyc(1, 8'h38, 1);
        chk("full_pp_count", 32'(bus.count),         32'd8);
        chk("full_pp_ovf",   32'(bus.Fifo_overflow), 32'd0);
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        // stall handling
        cyc(0, 8'h00, 0, 8'h01, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1, 8'hAA, 0);
        chk("stall_count", 32'(bus.count), 32'd0);
        cyc(0, 8'h00, 0, 8'h00, 8'h01);
        chk("stall_release", 32'(bus.stalled), 32'd0);
        cyc(1, 8'hAA, 0);
        cyc(0, 8'h00, 0, 8'h01, 8'h01);
        chk("pausa_wins", 32'(bus.stalled), 32'd1);
        cyc(0, 8'h00, 0, 8'h00, 8'h02);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) cyc(1, 8'h40 + 8'(i), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_count",   32'(bus.count),         32'd0);
        chk("areset_empty",   32'(bus.empty_Fifo),    32'd1);
        chk("areset_ae",      32'(bus.almost_empty),  32'd1);
        chk("areset_data",    32'(bus.data_Fifo),     32'd0);
        chk("areset_stalled", 32'(bus.stalled),       32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // inverted thresholds, push+pop on empty
        bus.thr_af = 4'd2;
        bus.thr_ae = 4'd5;
        cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
        cyc(0, 8'h00, 0);
        cyc(1, 8'h60, 1);
        cyc(1, 8'h61, 0);
        cyc(1, 8'h62, 0);
        chk("inv_af", 32'(bus.almost_full),  32'd1);
        chk("inv_ae", 32'(bus.almost_empty), 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
